fb_ar_remap: RTL and testbench
==============================

# fb_ar_remap

Parametrised framebuffer read-address remapper with N-deep swap queue and registered AXI AR skid path. Sits between the display scan-out core (issues frame-relative AR offsets) and the memory interconnect. Adds the currently displayed buffer base to every read request. Commits queued buffer swaps either immediately or only at frame start (vsync), for double, triple or quad buffering.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `ID_WIDTH`, 4: AR ID width.
- `QUEUE_DEPTH`, 2: pending swap entries (1..3); 1 gives double buffering, 2 triple.
- `FB_ADDR_DEFAULT`, 32'h01E00000: reset base address.
- `FB_SIZE_BYTES`, 1024*600*4: framebuffer span; used only with bounds check.
- `aclk` in 1: the only clock.
- `resetn` in 1: reset, synchronous, active-low.
- `swap_valid` in 1: swap request; new base on `swap_addr`.
- `swap_ready` out 1: queue not full.
- `swap_addr` in ADDR_WIDTH: new framebuffer base.
- `enable_vsync` in 1: 1 = commit only at frame start; 0 = commit immediately.
- `swap_done` out 1: one-cycle pulse per committed swap.
- `active_addr` out ADDR_WIDTH: base currently applied.
- `pending_count` out 2: occupied queue entries.
- `s_axi_arid/araddr/arlen/arburst/arvalid` in ID/ADDR/8/2/1: relative request from the scan-out core.
- `s_axi_arready` out 1.
- `m_axi_arid/araddr/arlen/arburst` out ID/ADDR/8/2: remapped request.
- `m_axi_arsize` out 3: constant 2. `m_axi_arqos` out 4: constant 4'hF. `m_axi_arlock/arcache/arprot` out: constant 0.
- `m_axi_arvalid` out 1; `m_axi_arready` in 1.
- `bounds_err` out 1: sticky out-of-range flag; present only with FB_REMAP_BOUNDS_CHECK_EN.

## Operation
- Swap queue: FIFO of QUEUE_DEPTH bases. Push on `swap_valid && swap_ready`.
- Commit condition, vsync mode: an S-side AR handshake with `s_axi_araddr == 0` while the queue is non-empty. Head pops to `active_addr`. That same beat is remapped with the new base.
- Commit condition, immediate mode: head pops every cycle the queue is non-empty, one entry per cycle.
- Each commit pulses `swap_done` in the following cycle.
- Remap: `m_axi_araddr = (base + s_axi_araddr)` truncated to ADDR_WIDTH. base is the post-commit value for that cycle. ID, len and burst pass through unchanged.
- AR path: output register plus one skid register, giving full throughput. Request ordering is preserved.
- Simultaneous push and pop: both occur and `pending_count` is unchanged. Push to an empty queue while a commit-eligible beat arrives: the entry is not usable until the next cycle.
- Queue full: `swap_ready = 0`. Further requests stall and none are dropped.
- Mode change with entries pending: the new mode applies from the next cycle.

## Timing
- Reset values:
  - `active_addr = FB_ADDR_DEFAULT`
  - `pending_count = 0`
  - `swap_ready = 1`
  - `swap_done = 0`
  - `m_axi_arvalid = 0`
  - `s_axi_arready = 1`
  - skid empty; `bounds_err = 0`
- Reset mid-burst drops in-flight and queued requests.
- AR latency: S handshake in cycle n gives `m_axi_arvalid` high in n+1.
- `s_axi_arready` is registered: `s_axi_arready = !skid_valid`.
- Skid fills when the output register holds an unaccepted beat and a new beat arrives. The skid drains into the output register on an `m_axi_arready` handshake.
- `m_axi_ar*` is stable while `arvalid && !arready`.
- `swap_ready` is registered, derived from next `pending_count`.

## Configuration
- Macro: `FB_REMAP_BOUNDS_CHECK_EN`.
- Defined: offset ≥ FB_SIZE_BYTES sets `bounds_err`, which stays set until reset. The address is wrapped to `offset - FB_SIZE_BYTES` (single subtraction) before adding base. The check adds no extra latency.
- Undefined: no check, no wrap; `bounds_err` is tied 0.

## Structure
- Package `fb_remap_pkg`: AXI constants (size = 2, burst INCR = 2'b01, qos all-ones) and the `ar_beat_t` struct {id, addr, len, burst}.
- Sub-module `fb_swap_queue`: small synchronous FIFO with push/pop/count/head. The remap and skid logic stays in the top.

## Test plan
- Reset then 4 AR beats, offsets 0/0x100/0x200/0x300, arready=1 → m_araddr 0x01E00000..0x01E00300 at one beat per cycle, each 1 cycle after acceptance.
- vsync=1, push 0x02000000, then beats at offsets 0x40 then 0 → first beat maps to 0x01E00040. Offset-0 beat maps to 0x02000000. `swap_done` pulses once.
- vsync=1, QUEUE_DEPTH=2, push A, B and C → C stalls (swap_ready=0). Two frame starts commit A then B. C enters after the first commit.
- m_arready held 0 for 5 cycles with continuous S traffic → s_arready drops after 2 beats. Beat order, address and ID are preserved when released.
- vsync=0, push 0x03000000 → `active_addr` updates the next cycle without any AR traffic. `swap_done` pulses.
- With FB_REMAP_BOUNDS_CHECK_EN, offset FB_SIZE_BYTES+0x10 → m_araddr = base+0x10 and `bounds_err` is set until reset.

Source files
------------

// File: rtl/fb_remap_pkg.sv
// fb_remap_pkg: AXI read-address constants and the AR beat record shared by the
// framebuffer remapper. Beat fields are sized for the widest supported bus;
// users cast to their own ADDR/ID widths.
package fb_remap_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_QOS_MAX    = 4'hF;

    localparam int BEAT_ID_W   = 16;
    localparam int BEAT_ADDR_W = 64;

    typedef struct packed {
        logic [BEAT_ID_W-1:0]   id;
        logic [BEAT_ADDR_W-1:0] addr;
        logic [7:0]             len;
        logic [1:0]             burst;
    } ar_beat_t;

endpackage

// File: rtl/fb_ar_remap_if.sv
// fb_ar_remap_if: AXI AR channel subset (id/addr/len/burst + valid/ready) used on
// both the scan-out side and the interconnect side of the remapper.
interface fb_ar_remap_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    modport master (output arid, araddr, arlen, arburst, arvalid, input arready);
    modport slave  (input arid, araddr, arlen, arburst, arvalid, output arready);
endinterface

// File: rtl/fb_swap_queue.sv
// fb_swap_queue: tiny FIFO of pending framebuffer bases. Entry 0 is always the
// head. Push is ignored when full and pop is ignored when empty; ready and count
// are registered.
module fb_swap_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             ready
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       count_q;
    logic [1:0]       count_next;
    logic [1:0]       wr_idx;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && ready;
    assign pop_ok  = pop && (count_q != 2'd0);

    // Next occupancy and the slot a push lands in once a same-cycle pop has shifted.
    always_comb begin
        count_next = count_q;
        wr_idx     = count_q;
        if (pop_ok) begin
            count_next = count_next - 2'd1;
            wr_idx     = count_q - 2'd1;
        end
        if (push_ok) begin
            count_next = count_next + 2'd1;
        end
    end

    // Storage: shift toward the head on pop, then write the new entry behind the tail.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            end
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == 2'(i)) mem[i] <= din;
                end
            end
        end
    end

    // Occupancy and ready flag, both taken from the post-update count.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            count_q <= 2'd0;
            ready   <= 1'b1;
        end else begin
            count_q <= count_next;
            ready   <= (count_next < 2'(DEPTH));
        end
    end

    assign head  = mem[0];
    assign count = count_q;
endmodule

// File: rtl/fb_ar_remap.sv
// fb_ar_remap: adds the displayed framebuffer base to every scan-out AR request,
// commits queued buffer swaps immediately or at frame start (offset-0 beat), and
// registers the AR path through an output register plus one skid slot.
// Optional feature: define FB_REMAP_BOUNDS_CHECK_EN to wrap and flag offsets that
// run past FB_SIZE_BYTES.
module fb_ar_remap
    import fb_remap_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    ID_WIDTH        = 4,
    parameter int                    QUEUE_DEPTH     = 2,
    parameter logic [ADDR_WIDTH-1:0] FB_ADDR_DEFAULT = 32'h01E00000,
    parameter int unsigned           FB_SIZE_BYTES   = 1024 * 600 * 4
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  swap_valid,
    output logic                  swap_ready,
    input  logic [ADDR_WIDTH-1:0] swap_addr,
    input  logic                  enable_vsync,
    output logic                  swap_done,
    output logic [ADDR_WIDTH-1:0] active_addr,
    output logic [1:0]            pending_count,
    fb_ar_remap_if.slave          s_axi,
    fb_ar_remap_if.master         m_axi,
    output logic [2:0]            m_axi_arsize,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  bounds_err
);
    logic [ADDR_WIDTH-1:0] active_q;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  vsync_mode;
    logic                  pop;
    logic                  done_q;
    logic                  s_hs;
    logic                  m_hs;
    logic                  out_valid;
    logic                  skid_valid;
    ar_beat_t              in_beat;
    ar_beat_t              out_beat;
    ar_beat_t              skid_beat;
    logic                  unused_beat_bits;

    fb_swap_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_queue (
        .aclk   (aclk),
        .resetn (resetn),
        .push   (swap_valid),
        .pop    (pop),
        .din    (swap_addr),
        .head   (head),
        .count  (pending_count),
        .ready  (swap_ready)
    );

    assign s_axi.arready = !skid_valid;
    assign s_hs          = s_axi.arvalid && !skid_valid;
    assign m_hs          = out_valid && m_axi.arready;

`ifdef FB_REMAP_BOUNDS_CHECK_EN
    logic out_of_range;
    logic bounds_q;

    // Out-of-range offsets are folded back by one framebuffer span.
    always_comb begin
        out_of_range = (s_axi.araddr >= ADDR_WIDTH'(FB_SIZE_BYTES));
        offset       = s_axi.araddr;
        if (out_of_range) offset = s_axi.araddr - ADDR_WIDTH'(FB_SIZE_BYTES);
    end

    // Sticky error: any accepted out-of-range beat latches it until reset.
    always_ff @(posedge aclk) begin
        if (!resetn)                   bounds_q <= 1'b0;
        else if (s_hs && out_of_range) bounds_q <= 1'b1;
    end

    assign bounds_err = bounds_q;
`else
    logic unused_size;
    assign unused_size = ^FB_SIZE_BYTES;
    assign offset      = s_axi.araddr;
    assign bounds_err  = 1'b0;
`endif

    // Commit decision; a committing beat already sees the new base.
    always_comb begin
        pop = 1'b0;
        if (pending_count != 2'd0) begin
            pop = vsync_mode ? (s_hs && (s_axi.araddr == '0)) : 1'b1;
        end
        base = pop ? head : active_q;
    end

    // Remapped beat as it would enter the output path this cycle.
    always_comb begin
        in_beat       = '0;
        in_beat.id    = BEAT_ID_W'(s_axi.arid);
        in_beat.addr  = BEAT_ADDR_W'(base + offset);
        in_beat.len   = s_axi.arlen;
        in_beat.burst = s_axi.arburst;
    end

    // Active base, commit pulse and the mode latched for the next cycle's decision.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            active_q   <= FB_ADDR_DEFAULT;
            done_q     <= 1'b0;
            vsync_mode <= 1'b0;
        end else begin
            active_q   <= base;
            done_q     <= pop;
            vsync_mode <= enable_vsync;
        end
    end

    // Output register with one skid slot: the skid only fills while the output is stalled.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
        end else if (!out_valid || m_hs) begin
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (s_hs) begin
                out_beat  <= in_beat;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (s_hs) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign unused_beat_bits = ^out_beat;

    assign m_axi.arvalid = out_valid;
    assign m_axi.arid    = ID_WIDTH'(out_beat.id);
    assign m_axi.araddr  = ADDR_WIDTH'(out_beat.addr);
    assign m_axi.arlen   = out_beat.len;
    assign m_axi.arburst = out_beat.burst;

    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arqos   = AXI_QOS_MAX;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

    assign swap_done   = done_q;
    assign active_addr = active_q;
endmodule

// File: tb/tb_fb_ar_remap.sv
// tb_fb_ar_remap: directed table and hand sequences for the framebuffer remapper,
// then randomized traffic compared every cycle against a queue-based model.
module tb_fb_ar_remap;
    import fb_remap_pkg::*;

    localparam int          AW         = 32;
    localparam int          IW         = 4;
    localparam int          QD         = 2;
    localparam logic [31:0] FB_DEFAULT = 32'h01E00000;
    localparam logic [31:0] FB_SIZE    = 32'd2457600;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } tb_beat_t;

    typedef struct {
        logic        s_valid;
        logic [31:0] s_addr;
        logic [3:0]  s_id;
        logic        m_ready;
        logic        exp_m_valid;
        logic [31:0] exp_m_addr;
        logic        exp_s_ready;
    } vec_t;

    logic        aclk;
    logic        resetn;
    logic        swap_valid;
    logic        swap_ready;
    logic [31:0] swap_addr;
    logic        enable_vsync;
    logic        swap_done;
    logic [31:0] active_addr;
    logic [1:0]  pending_count;
    logic [2:0]  m_axi_arsize;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        bounds_err;

    fb_ar_remap_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_bus ();
    fb_ar_remap_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_bus ();

    fb_ar_remap #(
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IW),
        .QUEUE_DEPTH     (QD),
        .FB_ADDR_DEFAULT (FB_DEFAULT),
        .FB_SIZE_BYTES   (FB_SIZE)
    ) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .swap_valid    (swap_valid),
        .swap_ready    (swap_ready),
        .swap_addr     (swap_addr),
        .enable_vsync  (enable_vsync),
        .swap_done     (swap_done),
        .active_addr   (active_addr),
        .pending_count (pending_count),
        .s_axi         (s_bus),
        .m_axi         (m_bus),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .bounds_err    (bounds_err)
    );

    // Free-running clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vec_count = 0;
    int err_count = 0;

    // Reference model: displayed base, pending bases, beats held in the AR path.
    logic [31:0] mdl_active;
    logic [31:0] mdl_pend[$];
    tb_beat_t    mdl_ar[$];
    logic        mdl_vsync;
    logic        mdl_done;
    logic        mdl_berr;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic ev, input logic av,
                                 input logic [3:0] aid, input logic [31:0] aaddr, input logic mr);
        swap_valid     = sv;
        swap_addr      = sa;
        enable_vsync   = ev;
        s_bus.arvalid  = av;
        s_bus.arid     = aid;
        s_bus.araddr   = aaddr;
        s_bus.arlen    = 8'(aid) + 8'd3;
        s_bus.arburst  = AXI_BURST_INCR;
        m_bus.arready  = mr;
    endtask

    task automatic modelReset();
        mdl_active = FB_DEFAULT;
        mdl_pend.delete();
        mdl_ar.delete();
        mdl_vsync = 1'b0;
        mdl_done  = 1'b0;
        mdl_berr  = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("active_addr", active_addr, mdl_active);
        checkOutput("pending_count", pending_count, mdl_pend.size());
        checkOutput("swap_ready", swap_ready, mdl_pend.size() < QD);
        checkOutput("swap_done", swap_done, mdl_done);
        checkOutput("s_arready", s_bus.arready, mdl_ar.size() < 2);
        checkOutput("m_arvalid", m_bus.arvalid, mdl_ar.size() > 0);
        if (mdl_ar.size() > 0) begin
            checkOutput("m_araddr", m_bus.araddr, mdl_ar[0].addr);
            checkOutput("m_arid", m_bus.arid, mdl_ar[0].id);
            checkOutput("m_arlen", m_bus.arlen, mdl_ar[0].len);
            checkOutput("m_arburst", m_bus.arburst, mdl_ar[0].burst);
        end
        checkOutput("m_arside", {m_axi_arsize, m_axi_arqos, m_axi_arlock, m_axi_arcache, m_axi_arprot},
                    {3'd2, 4'hF, 1'b0, 4'd0, 3'd0});
        checkOutput("bounds_err", bounds_err, mdl_berr);
    endtask

    // One clock: predict from current inputs and model state, step, then compare.
    task automatic tick();
        bit          s_ok, m_ok, pop, push, oob;
        logic [31:0] base, off;
        if (!resetn) begin
            @(posedge aclk);
            #1;
            modelReset();
            checkAll();
            return;
        end
        s_ok = s_bus.arvalid && (mdl_ar.size() < 2);
        m_ok = (mdl_ar.size() > 0) && m_bus.arready;
        pop  = (mdl_pend.size() > 0) && (mdl_vsync ? (s_ok && s_bus.araddr == 32'd0) : 1'b1);
        push = swap_valid && (mdl_pend.size() < QD);
        base = pop ? mdl_pend[0] : mdl_active;
        off  = s_bus.araddr;
        oob  = 1'b0;
`ifdef FB_REMAP_BOUNDS_CHECK_EN
        if (off >= FB_SIZE) begin
            oob = 1'b1;
            off = off - FB_SIZE;
        end
`endif
        @(posedge aclk);
        #1;
        if (m_ok) void'(mdl_ar.pop_front());
        if (s_ok) mdl_ar.push_back('{s_bus.arid, base + off, s_bus.arlen, s_bus.arburst});
        if (pop) mdl_active = mdl_pend.pop_front();
        mdl_done = pop;
        if (push) mdl_pend.push_back(swap_addr);
        mdl_vsync = enable_vsync;
        if (s_ok && oob) mdl_berr = 1'b1;
        checkAll();
    endtask

    // Stimulus sequence.
    initial begin
        logic        ev_r;
        logic [31:0] ra;

        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        checkOutput("rst_active", active_addr, FB_DEFAULT);
        checkOutput("rst_pending", pending_count, 2'd0);
        checkOutput("rst_swap_ready", swap_ready, 1'b1);
        checkOutput("rst_swap_done", swap_done, 1'b0);
        checkOutput("rst_m_valid", m_bus.arvalid, 1'b0);
        checkOutput("rst_s_ready", s_bus.arready, 1'b1);
        checkOutput("rst_bounds", bounds_err, 1'b0);
        resetn = 1'b1;

        // Four back-to-back beats at full throughput.
        vecs[0] = '{1'b1, 32'h000, 4'h1, 1'b1, 1'b1, 32'h01E00000, 1'b1};
        vecs[1] = '{1'b1, 32'h100, 4'h2, 1'b1, 1'b1, 32'h01E00100, 1'b1};
        vecs[2] = '{1'b1, 32'h200, 4'h3, 1'b1, 1'b1, 32'h01E00200, 1'b1};
        vecs[3] = '{1'b1, 32'h300, 4'h4, 1'b1, 1'b1, 32'h01E00300, 1'b1};
        vecs[4] = '{1'b0, 32'h000, 4'h0, 1'b1, 1'b0, 32'h0,        1'b1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, vecs[i].s_valid, vecs[i].s_id, vecs[i].s_addr, vecs[i].m_ready);
            tick();
            checkOutput("tbl_m_valid", m_bus.arvalid, vecs[i].exp_m_valid);
            checkOutput("tbl_s_ready", s_bus.arready, vecs[i].exp_s_ready);
            if (vecs[i].exp_m_valid) checkOutput("tbl_m_addr", m_bus.araddr, vecs[i].exp_m_addr);
        end

        // Frame-start commit: only the offset-0 beat picks up the new base.
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 32'h02000000, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 4'h2, 32'h40, 1);
        tick();
        checkOutput("vs_pre_addr", m_bus.araddr, 32'h01E00040);
        checkOutput("vs_pre_done", swap_done, 1'b0);
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h0, 1);
        tick();
        checkOutput("vs_commit_addr", m_bus.araddr, 32'h02000000);
        checkOutput("vs_commit_active", active_addr, 32'h02000000);
        checkOutput("vs_done_pulse", swap_done, 1'b1);
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        tick();
        checkOutput("vs_done_clear", swap_done, 1'b0);

        // Queue full: C waits until A has been committed.
        applyStimulus(1, 32'h04000000, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 32'h05000000, 1, 0, 0, 0, 1);
        tick();
        checkOutput("qf_ready_low", swap_ready, 1'b0);
        applyStimulus(1, 32'h06000000, 1, 0, 0, 0, 1);
        tick();
        tick();
        checkOutput("qf_stall_count", pending_count, 2'd2);
        applyStimulus(1, 32'h06000000, 1, 1, 4'h4, 32'h0, 1);
        tick();
        checkOutput("qf_commit_a", active_addr, 32'h04000000);
        checkOutput("qf_ready_back", swap_ready, 1'b1);
        applyStimulus(1, 32'h06000000, 1, 0, 0, 0, 1);
        tick();
        checkOutput("qf_c_entered", pending_count, 2'd2);
        applyStimulus(0, 0, 1, 1, 4'h5, 32'h0, 1);
        tick();
        checkOutput("qf_commit_b", active_addr, 32'h05000000);
        checkOutput("qf_b_addr", m_bus.araddr, 32'h05000000);
        applyStimulus(0, 0, 1, 1, 4'h6, 32'h0, 1);
        tick();
        checkOutput("qf_commit_c", active_addr, 32'h06000000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();

        // Backpressure: two beats stored, then ready drops; order kept on release.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(8 + i), 32'(32'h1000 * (i + 1)), 0);
            tick();
            checkOutput("bp_s_ready", s_bus.arready, (i == 0) ? 1'b1 : 1'b0);
        end
        checkOutput("bp_hold_id", m_bus.arid, 4'h8);
        checkOutput("bp_hold_addr", m_bus.araddr, 32'h06001000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("bp_second_id", m_bus.arid, 4'h9);
        checkOutput("bp_second_addr", m_bus.araddr, 32'h06002000);
        tick();
        checkOutput("bp_drained", m_bus.arvalid, 1'b0);

        // Immediate mode: commit without any AR traffic.
        applyStimulus(1, 32'h03000000, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("imm_active", active_addr, 32'h03000000);
        checkOutput("imm_done", swap_done, 1'b1);
        tick();

`ifdef FB_REMAP_BOUNDS_CHECK_EN
        // Offset past the framebuffer is wrapped and latches the error flag.
        applyStimulus(0, 0, 0, 1, 4'h1, FB_SIZE + 32'h10, 1);
        tick();
        checkOutput("bc_wrap_addr", m_bus.araddr, 32'h03000010);
        checkOutput("bc_err_set", bounds_err, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        checkOutput("bc_err_sticky", bounds_err, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checkOutput("bc_err_cleared", bounds_err, 1'b0);
`endif

        // Randomized traffic with occasional resets and mode flips.
        ev_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 15) == 0) ev_r = ~ev_r;
            ra = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'h003FFFFC);
            applyStimulus($urandom_range(0, 5) == 0, $urandom & 32'hFFFFF000, ev_r,
                          $urandom_range(0, 9) < 7, 4'($urandom), ra, $urandom_range(0, 9) < 6);
            s_bus.arlen   = 8'($urandom);
            s_bus.arburst = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
